irq_rr_scheduler: RTL and testbench
===================================

// Module: irq_rr_scheduler
// PURPOSE
//  Serialises the per-source level requests from the IRQ edge-capture shim (irq_req, held until acked)
//  onto a single vector channel toward the host interrupt controller. Round-robin fair among unmasked
//  sources; one interrupt in flight at a time; returns a one-cycle irq_ack to the shim on acceptance.
//  Waits for host end-of-interrupt (EOI), with optional timeout. Sits between the shim and the host.
// PARAMETERS
//  WIDTH    16  number of interrupt sources (>=2)
//  IDX_W     4  vector index width, = $clog2(WIDTH)
//  HOLDOFF   2  idle cycles forced after EOI before next arbitration (0 = none)
//  TIMEOUT 1024 max cycles waited for eoi before abort (0 = wait forever)
// PORTS
//  clk          in   1      single clock, same domain as the shim
//  rstn         in   1      asynchronous active-low reset
//  irq_req      in   WIDTH  pending requests from shim, level, held until irq_ack
//  irq_ack      out  WIDTH  one-hot, one-cycle acknowledge back to shim
//  irq_mask     in   WIDTH  1 = source not eligible (its request stays pending, never acked)
//  vec_valid    out  1      vector presented to host
//  vec_id       out  IDX_W  source index of presented vector
//  vec_ready    in   1      host accepts vector when vec_valid & vec_ready
//  eoi          in   1      host end-of-interrupt pulse for the in-flight vector
//  busy         out  1      high in any state other than IDLE
//  timeout_err  out  1      sticky: EOI timeout occurred
//  err_clr      in   1      clears timeout_err (one cycle)
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE, rr_ptr=0, irq_ack=0, vec_valid=0, vec_id=0, busy=0,
//   timeout_err=0, counters=0. Reset mid-transaction aborts it; no ack is issued.
//  States: IDLE -> OFFER -> WAIT_EOI -> (HOLD) -> IDLE. All outputs registered.
//  IDLE: elig = irq_req & ~irq_mask. If elig!=0, pick first set bit scanning rr_ptr, rr_ptr+1, ...
//   wrapping WIDTH-1 -> 0; next edge: vec_id<=pick, vec_valid<=1, state<=OFFER. Latency req->valid = 1 clk.
//  OFFER: vec_valid/vec_id held stable until handshake; mask changes or irq_req changes do not withdraw.
//   On vec_valid&vec_ready edge: vec_valid<=0, irq_ack[vec_id]<=1 (exactly one cycle),
//   rr_ptr <= (vec_id==WIDTH-1) ? 0 : vec_id+1, tmo_cnt<=0, state<=WAIT_EOI.
//  WAIT_EOI: irq_ack returns to 0. eoi=1 -> HOLD if HOLDOFF>0 else IDLE. eoi outside WAIT_EOI ignored
//   (including eoi coincident with the OFFER handshake). If TIMEOUT>0, tmo_cnt increments each cycle;
//   when tmo_cnt==TIMEOUT-1 and eoi=0: timeout_err<=1, leave as if eoi. eoi and expiry same cycle: eoi wins.
//  HOLD: count HOLDOFF cycles, then IDLE. No arbitration in HOLD.
//  timeout_err: set wins over err_clr in same cycle. busy = (state!=IDLE).
//  Counter widths: tmo_cnt $clog2(TIMEOUT+1), hold_cnt $clog2(HOLDOFF+1); no wrap possible.
//  At most one bit of irq_ack set at any time; at most one vector outstanding.
//  Since irq_req is cleared by the shim the cycle after irq_ack, the granted bit is low by next IDLE.
// TESTING
//  1 Reset: rstn=0 mid-OFFER -> vec_valid=0, irq_ack=0, busy=0 immediately; rr_ptr restarts at 0.
//  2 Single: irq_req=0x0010, vec_ready=1 -> vec_id=4 valid 1 clk later, irq_ack=0x0010 one cycle,
//    eoi -> busy low after HOLDOFF=2 cycles.
//  3 Round-robin: irq_req=0x8003 held, eoi after each -> order 0,1,15,0,1,15; wrap 15->0 verified.
//  4 Mask: irq_req=0x0006, irq_mask=0x0002 -> only id 2 served; clear mask -> id 1 served, never acked early.
//  5 Backpressure: vec_ready=0 for 20 cycles, toggle mask/irq_req -> vec_id stable, no ack until ready=1.
//  6 Timeout: TIMEOUT=8, no eoi -> timeout_err=1 at 8th WAIT_EOI cycle, next request served; eoi on same
//    cycle as expiry -> no error; err_clr -> timeout_err=0.

Source files
------------

// File: rtl/irq_rr_scheduler_if.sv
// Host-side vector channel of the IRQ round-robin scheduler:
// offered vector, its valid/ready handshake and the end-of-interrupt pulse.
interface irq_rr_scheduler_if #(
    parameter int IDX_W = 4
) ();
    logic             vec_valid;
    logic [IDX_W-1:0] vec_id;
    logic             vec_ready;
    logic             eoi;

    modport master (
        output vec_valid,
        output vec_id,
        input  vec_ready,
        input  eoi
    );

    modport slave (
        input  vec_valid,
        input  vec_id,
        output vec_ready,
        output eoi
    );
endinterface

// File: rtl/irq_rr_scheduler.sv
// Round-robin IRQ scheduler: serialises shim requests onto one host vector
// channel, one interrupt in flight, EOI wait with optional timeout.
module irq_rr_scheduler #(
    parameter int WIDTH   = 16,
    parameter int IDX_W   = 4,
    parameter int HOLDOFF = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [WIDTH-1:0]    irq_req,
    output logic [WIDTH-1:0]    irq_ack,
    input  logic [WIDTH-1:0]    irq_mask,
    irq_rr_scheduler_if.master  host,
    output logic                busy,
    output logic                timeout_err,
    input  logic                err_clr
);
    localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int HLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        WAIT_EOI,
        HOLD
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0] offer_id, offer_id_n;
    logic             offer_valid, offer_valid_n;
    logic [WIDTH-1:0] irq_ack_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic [HLD_W-1:0] hold_cnt, hold_cnt_n;
    logic             err_n;
    logic [WIDTH-1:0] elig;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   cand;
    logic             found;
    logic             expired;
    logic             done;

    assign elig           = irq_req & ~irq_mask;
    assign busy           = (state != IDLE);
    assign host.vec_valid = offer_valid;
    assign host.vec_id    = offer_id;
    assign expired        = (TIMEOUT > 0) && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // First eligible source scanning upward from rr_ptr with wrap-around
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(WIDTH)) begin
                cand = cand - (IDX_W+1)'(WIDTH);
            end
            if (!found && elig[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n       = state;
        rr_ptr_n      = rr_ptr;
        offer_valid_n = offer_valid;
        offer_id_n    = offer_id;
        irq_ack_n     = '0;
        tmo_cnt_n     = tmo_cnt;
        hold_cnt_n    = hold_cnt;
        done          = 1'b0;
        err_n         = err_clr ? 1'b0 : timeout_err;
        unique case (state)
            IDLE: begin
                if (found) begin
                    offer_valid_n = 1'b1;
                    offer_id_n    = pick;
                    state_n       = OFFER;
                end
            end
            OFFER: begin
                if (host.vec_ready) begin
                    offer_valid_n = 1'b0;
                    irq_ack_n     = WIDTH'(1) << offer_id;
                    rr_ptr_n      = (offer_id == IDX_W'(WIDTH - 1))
                                  ? '0 : offer_id + 1'b1;
                    tmo_cnt_n     = '0;
                    state_n       = WAIT_EOI;
                end
            end
            WAIT_EOI: begin
                if (TIMEOUT > 0) begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
                if (host.eoi) begin
                    done = 1'b1;
                end else if (expired) begin
                    done  = 1'b1;
                    err_n = 1'b1;
                end
                if (done) begin
                    hold_cnt_n = '0;
                    state_n    = (HOLDOFF > 0) ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (hold_cnt == HLD_W'(HOLDOFF - 1)) begin
                    state_n = IDLE;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            offer_valid <= 1'b0;
            offer_id    <= '0;
            irq_ack     <= '0;
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            offer_valid <= offer_valid_n;
            offer_id    <= offer_id_n;
            irq_ack     <= irq_ack_n;
            tmo_cnt     <= tmo_cnt_n;
            hold_cnt    <= hold_cnt_n;
            timeout_err <= err_n;
        end
    end
endmodule

// File: tb/tb_irq_rr_scheduler.sv
// Self-checking bench for irq_rr_scheduler: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_irq_rr_scheduler;
    localparam int W    = 16;
    localparam int IW   = 4;
    localparam int HOLD = 2;
    localparam int TMO  = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] irq_req = '0;
    logic [W-1:0] irq_mask = '0;
    logic [W-1:0] irq_ack;
    logic         busy;
    logic         timeout_err;
    logic         err_clr = 1'b0;

    int checks = 0;
    int fails  = 0;

    irq_rr_scheduler_if #(.IDX_W(IW)) host ();

    irq_rr_scheduler #(
        .WIDTH(W), .IDX_W(IW), .HOLDOFF(HOLD), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .irq_req(irq_req),
        .irq_ack(irq_ack),
        .irq_mask(irq_mask),
        .host(host.master),
        .busy(busy),
        .timeout_err(timeout_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Reference arbitration: first requesting index at or after ptr, modulo W
    function automatic int rr_first(logic [W-1:0] e, int ptr);
        for (int i = 0; i < W; i++) begin
            if (e[(ptr + i) % W]) return (ptr + i) % W;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; host.vec_ready = 1'b0; host.eoi = 1'b0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (host.vec_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", host.vec_valid); end
        checks++; if (irq_ack !== '0) begin fails++; $display("FAIL reset_ack got=%h exp=0", irq_ack); end
        checks++; if (host.vec_id !== '0) begin fails++; $display("FAIL reset_id got=%0d exp=0", host.vec_id); end
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
        rstn = 1'b1; irq_req = 16'h0100; host.vec_ready = 1'b1;
        step();
        checks++; if (host.vec_valid !== 1'b1 || host.vec_id !== 4'd8) begin fails++; $display("FAIL reset_first got=%b/%0d exp=1/8", host.vec_valid, host.vec_id); end
        step();
        irq_req = '0; host.eoi = 1'b1; step(); host.eoi = 1'b0; step(); step();
        irq_req = 16'h0202; host.vec_ready = 1'b0;
        step();
        checks++; if (host.vec_id !== 4'd9) begin fails++; $display("FAIL reset_pre_ptr got=%0d exp=9", host.vec_id); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (host.vec_valid !== 1'b0 || busy !== 1'b0 || irq_ack !== '0) begin fails++; $display("FAIL reset_async got=%b/%b/%h exp=0/0/0", host.vec_valid, busy, irq_ack); end
        step(); rstn = 1'b1;
        step();
        checks++; if (host.vec_valid !== 1'b1 || host.vec_id !== 4'd1) begin fails++; $display("FAIL reset_ptr got=%b/%0d exp=1/1", host.vec_valid, host.vec_id); end
        host.vec_ready = 1'b1;
        step();
        checks++; if (irq_ack !== 16'h0002) begin fails++; $display("FAIL reset_ack2 got=%h exp=0002", irq_ack); end
        irq_req = '0; host.eoi = 1'b1; step(); host.eoi = 1'b0; step(); step();
    endtask

    task automatic test_single();
        irq_req = 16'h0010;
        step();
        checks++; if (host.vec_valid !== 1'b1 || host.vec_id !== 4'd4) begin fails++; $display("FAIL single_vec got=%b/%0d exp=1/4", host.vec_valid, host.vec_id); end
        checks++; if (irq_ack !== '0) begin fails++; $display("FAIL single_early_ack got=%h exp=0", irq_ack); end
        step();
        checks++; if (irq_ack !== 16'h0010 || host.vec_valid !== 1'b0) begin fails++; $display("FAIL single_ack got=%h/%b exp=0010/0", irq_ack, host.vec_valid); end
        irq_req = '0;
        step();
        checks++; if (irq_ack !== '0) begin fails++; $display("FAIL single_ack_len got=%h exp=0", irq_ack); end
        host.eoi = 1'b1; step(); host.eoi = 1'b0;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_hold1 got=%b exp=1", busy); end
        step();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_hold2 got=%b exp=1", busy); end
        step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 15, 0, 1, 15};
        rstn = 1'b0; irq_req = 16'h8003; step(); rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (host.vec_valid !== 1'b1 || host.vec_id !== IW'(order[i])) begin fails++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, host.vec_id, order[i]); end
            step();
            checks++; if (irq_ack !== W'(1) << order[i]) begin fails++; $display("FAIL rr_ack[%0d] got=%h", i, irq_ack); end
            host.eoi = 1'b1; step(); host.eoi = 1'b0; step(); step();
            checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_idle[%0d] got=%b exp=0", i, busy); end
        end
        irq_req = '0;
        step();
    endtask

    task automatic test_mask();
        irq_req = 16'h0006; irq_mask = 16'h0002;
        step();
        checks++; if (host.vec_id !== 4'd2) begin fails++; $display("FAIL mask_pick got=%0d exp=2", host.vec_id); end
        step();
        checks++; if (irq_ack !== 16'h0004) begin fails++; $display("FAIL mask_ack got=%h exp=0004", irq_ack); end
        irq_req = 16'h0002;
        host.eoi = 1'b1; step(); host.eoi = 1'b0; step(); step();
        step();
        checks++; if (host.vec_valid !== 1'b0 || irq_ack !== '0 || busy !== 1'b0) begin fails++; $display("FAIL mask_block got=%b/%h/%b exp=0/0/0", host.vec_valid, irq_ack, busy); end
        irq_mask = '0;
        step();
        checks++; if (host.vec_valid !== 1'b1 || host.vec_id !== 4'd1) begin fails++; $display("FAIL mask_clear got=%b/%0d exp=1/1", host.vec_valid, host.vec_id); end
        step();
        checks++; if (irq_ack !== 16'h0002) begin fails++; $display("FAIL mask_ack1 got=%h exp=0002", irq_ack); end
        irq_req = '0;
        host.eoi = 1'b1; step(); host.eoi = 1'b0; step(); step();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        irq_req = 16'h0030; host.vec_ready = 1'b0;
        step();
        checks++; if (host.vec_id !== 4'd4) begin fails++; $display("FAIL bp_pick got=%0d exp=4", host.vec_id); end
        for (int i = 0; i < 20; i++) begin
            irq_req = W'($urandom); irq_mask = W'($urandom);
            step();
            checks++;
            if (host.vec_valid !== 1'b1 || host.vec_id !== 4'd4 || irq_ack !== '0) begin
                fails++;
                $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/4/0", i, host.vec_valid, host.vec_id, irq_ack);
            end
        end
        irq_req = 16'h0030; irq_mask = '0; host.vec_ready = 1'b1;
        step();
        checks++; if (irq_ack !== 16'h0010 || host.vec_valid !== 1'b0) begin fails++; $display("FAIL bp_ack got=%h/%b exp=0010/0", irq_ack, host.vec_valid); end
        irq_req = '0;
        host.eoi = 1'b1; step(); host.eoi = 1'b0; step(); step();
        bad = bad;
    endtask

    task automatic test_timeout();
        irq_req = 16'h0001;
        step();
        checks++; if (host.vec_id !== 4'd0) begin fails++; $display("FAIL tmo_pick got=%0d exp=0", host.vec_id); end
        step();
        irq_req = 16'h0800;
        repeat (TMO - 1) step();
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL tmo_early got=%b/%b exp=0/1", timeout_err, busy); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL tmo_set got=%b exp=1", timeout_err); end
        step(); step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_idle got=%b exp=0", busy); end
        step();
        checks++; if (host.vec_valid !== 1'b1 || host.vec_id !== 4'd11) begin fails++; $display("FAIL tmo_next got=%b/%0d exp=1/11", host.vec_valid, host.vec_id); end
        step();
        irq_req = '0; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL tmo_clr got=%b exp=0", timeout_err); end
        repeat (TMO - 2) step();
        host.eoi = 1'b1;
        step();
        host.eoi = 1'b0;
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL tmo_eoi_wins got=%b/%b exp=0/1", timeout_err, busy); end
        step(); step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_end got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        int ptr = 0, ph = 0, k = 0, gid = 0, eoi_at = 1, h = 0;
        logic err = 1'b0, nerr;
        logic [W-1:0] e, exp_ack;
        rstn = 1'b0; irq_req = '0; irq_mask = '0;
        host.vec_ready = 1'b0; host.eoi = 1'b0; err_clr = 1'b0;
        step(); rstn = 1'b1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if ($urandom_range(0, 3) == 0) irq_req = irq_req | (W'(1) << $urandom_range(0, W - 1));
            if (ph == 2 && k == 1) irq_req[gid] = 1'b0;
            if ($urandom_range(0, 7) == 0) irq_mask = W'($urandom & $urandom);
            host.vec_ready = ($urandom_range(0, 2) != 0);
            host.eoi = (ph == 2) ? (k == eoi_at) : ($urandom_range(0, 5) == 0);
            err_clr = ($urandom_range(0, 9) == 0);
            nerr = err_clr ? 1'b0 : err;
            case (ph)
                0: begin
                    e = irq_req & ~irq_mask;
                    if (e != '0) begin gid = rr_first(e, ptr); ph = 1; end
                end
                1: if (host.vec_ready) begin
                    ptr = (gid + 1) % W; ph = 2; k = 1;
                    eoi_at = $urandom_range(1, TMO + 2);
                end
                2: if (host.eoi || k == TMO) begin
                    if (!host.eoi) nerr = 1'b1;
                    ph = (HOLD > 0) ? 3 : 0; h = 1;
                end else k++;
                default: if (h == HOLD) ph = 0; else h++;
            endcase
            err = nerr;
            step();
            exp_ack = (ph == 2 && k == 1) ? (W'(1) << gid) : '0;
            checks++;
            if (host.vec_valid !== (ph == 1) || busy !== (ph != 0) || irq_ack !== exp_ack || timeout_err !== err) begin
                fails++;
                $display("FAIL rand_c%0d got v%b b%b a%h e%b exp v%b b%b a%h e%b", cyc, host.vec_valid, busy, irq_ack, timeout_err, ph == 1, ph != 0, exp_ack, err);
            end
            if (ph == 1) begin
                checks++;
                if (host.vec_id !== IW'(gid)) begin fails++; $display("FAIL rand_id_c%0d got=%0d exp=%0d", cyc, host.vec_id, gid); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        host.vec_ready = 1'b0;
        host.eoi = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_mask();
        test_backpressure();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
